// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: EXE/MEM to MEM/WB with a req/ack data-memory handshake.
// Optional macro MEM_ALIGN_CHECK_EN rejects word-misaligned accesses in IDLE.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] EXE_MEM_Result,
    input  logic [31:0] EXE_MEM_Rt,
    input  logic [4:0]  EXE_MEM_DstReg,
    input  logic        EXE_MEM_MemRead,
    input  logic        EXE_MEM_MemWrite,
    input  logic        EXE_MEM_MemtoReg,
    input  logic        EXE_MEM_RegWrite,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [31:0] MEM_WB_Result,
    output logic [31:0] MEM_WB_ReadData,
    output logic [4:0]  MEM_WB_DstReg,
    output logic        MEM_WB_MemtoReg,
    output logic        MEM_WB_RegWrite
);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_wb_result;
    logic [31:0]       r_wb_rdata;
    logic [4:0]        r_wb_dst;
    logic              r_wb_m2r;
    logic              r_wb_rw;

    logic w_access;
    logic w_misal;
    logic w_issue;
    logic w_reject;
    logic w_timeout;
    logic w_stall;

    assign w_access = EXE_MEM_MemRead | EXE_MEM_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misal = |EXE_MEM_Result[1:0];
`else
    assign w_misal = 1'b0;
`endif

    assign w_issue   = (r_state == S_IDLE) & w_access & ~w_misal;
    assign w_reject  = (r_state == S_IDLE) & w_access & w_misal;
    assign w_timeout = (r_state == S_REQ) & ~mem_ack &
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_next  = S_REQ;
                    w_stall = 1'b1;
                end
            end
            S_REQ: begin
                w_stall = ~mem_ack & ~w_timeout;
                if (mem_ack || w_timeout)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Gated by reset so the front end is released while the access is abandoned
    assign mem_stall = rst_n & w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_wb_result <= '0;
            r_wb_rdata  <= '0;
            r_wb_dst    <= '0;
            r_wb_m2r    <= 1'b0;
            r_wb_rw     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_timeout | w_reject;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_req   <= 1'b1;
                        r_we    <= EXE_MEM_MemWrite;
                        r_addr  <= EXE_MEM_Result;
                        r_wdata <= EXE_MEM_Rt;
                        r_cnt   <= '0;
                        r_wb_rw <= 1'b0;
                    end else if (w_reject) begin
                        r_wb_rw <= 1'b0;
                    end else begin
                        r_wb_result <= EXE_MEM_Result;
                        r_wb_rdata  <= '0;
                        r_wb_dst    <= EXE_MEM_DstReg;
                        r_wb_m2r    <= EXE_MEM_MemtoReg;
                        r_wb_rw     <= EXE_MEM_RegWrite;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_req       <= 1'b0;
                        r_wb_result <= EXE_MEM_Result;
                        r_wb_rdata  <= r_we ? 32'd0 : mem_rdata;
                        r_wb_dst    <= EXE_MEM_DstReg;
                        r_wb_m2r    <= EXE_MEM_MemtoReg;
                        r_wb_rw     <= EXE_MEM_RegWrite;
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_wb_rw <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_req <= 1'b0;
            endcase
        end
    end

    assign mem_req         = r_req;
    assign mem_we          = r_we;
    assign mem_addr        = r_addr;
    assign mem_wdata       = r_wdata;
    assign mem_err         = r_err;
    assign MEM_WB_Result   = r_wb_result;
    assign MEM_WB_ReadData = r_wb_rdata;
    assign MEM_WB_DstReg   = r_wb_dst;
    assign MEM_WB_MemtoReg = r_wb_m2r;
    assign MEM_WB_RegWrite = r_wb_rw;

endmodule
